// File: rtl/pipelined_addsub.sv
// pipelined_addsub: parametrised N-bit adder/subtractor split into STAGE_W-bit
// slices, one slice added per pipeline stage with the carry registered between
// stages. Valid/ready handshakes on both sides; a stall freezes the whole pipe.
//
// Optional feature: define ADDSUB_SAT_EN to replace an overflowing result with
// the signed saturation value (ovf is still reported, c_out is untouched).
// Without the macro the result simply wraps and no saturation logic exists.
//
// Pipeline organisation (NSTG = WIDTH/STAGE_W):
//   slot 0        : operands captured from the input port (b already
//                   conditionally inverted, stage-0 carry selected)
//   slot k+1      : result of adding slice k onto slot k
//   slot NSTG     : output register (sum / c_out / ovf / out_valid)
// An accepted operation therefore reaches the output exactly NSTG clocks after
// the edge at which it was accepted.
//
// WIDTH must be a multiple of STAGE_W, WIDTH >= 2 and 1 <= NSTG <= 16.

module pipelined_addsub #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSTG = WIDTH / STAGE_W;

    // Per-slot state. Slot 0 is the input capture, slot NSTG the output.
    logic             vld_d [0:NSTG];
    logic             vld_q [0:NSTG];
    logic             cy_d  [0:NSTG];
    logic             cy_q  [0:NSTG];
    logic [WIDTH-1:0] res_d [0:NSTG];
    logic [WIDTH-1:0] res_q [0:NSTG];

    // Operands travel alongside the partial result so that upper slices stay
    // aligned with the carry that will eventually reach them. The output slot
    // does not need them.
    logic [WIDTH-1:0] opa_d [0:NSTG-1];
    logic [WIDTH-1:0] opa_q [0:NSTG-1];
    logic [WIDTH-1:0] opb_d [0:NSTG-1];
    logic [WIDTH-1:0] opb_q [0:NSTG-1];

    logic             ovf_d;
    logic             ovf_q;
    logic             stall_s;

    // Adds slice k of the two operands plus the incoming carry and merges the
    // slice into the partial result. Returns {carry_out, updated_result}.
    function automatic logic [WIDTH:0] add_slice(
        input logic [WIDTH-1:0] opa,
        input logic [WIDTH-1:0] opb,
        input logic [WIDTH-1:0] res,
        input logic             cin,
        input int               k
    );
        logic [STAGE_W:0] slice_v;
        logic [WIDTH-1:0] nxt_v;
        slice_v = {1'b0, opa[k*STAGE_W +: STAGE_W]}
                + {1'b0, opb[k*STAGE_W +: STAGE_W]}
                + {{STAGE_W{1'b0}}, cin};
        nxt_v = res;
        nxt_v[k*STAGE_W +: STAGE_W] = slice_v[STAGE_W-1:0];
        return {slice_v[STAGE_W], nxt_v};
    endfunction

`ifdef ADDSUB_SAT_EN
    // Signed saturation value chosen by the sign of operand A.
    function automatic logic [WIDTH-1:0] sat_value(input logic a_msb);
        logic [WIDTH-1:0] v;
        if (a_msb) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // Stall whenever the output holds a result nobody takes; everything freezes.
    always_comb begin
        stall_s = vld_q[NSTG] & ~out_ready;
    end

    assign in_ready  = ~stall_s;
    assign out_valid = vld_q[NSTG];
    assign sum       = res_q[NSTG];
    assign c_out     = cy_q[NSTG];
    assign ovf       = ovf_q;

    // Next-state for every pipeline slot: shift when not stalled, hold otherwise.
    always_comb begin : next_state_calc
        logic [WIDTH:0] add_v;
        logic           msb_a_v;
        logic           msb_b_v;

        add_v   = {(WIDTH+1){1'b0}};
        msb_a_v = 1'b0;
        msb_b_v = 1'b0;
        ovf_d   = ovf_q;
        for (int k = 0; k <= NSTG; k++) begin
            vld_d[k] = vld_q[k];
            cy_d[k]  = cy_q[k];
            res_d[k] = res_q[k];
        end
        for (int k = 0; k < NSTG; k++) begin
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
        end

        if (stall_s) begin
            // Whole pipe holds: the defaults above already keep every slot.
            ovf_d = ovf_q;
        end else begin
            // Slot 0: capture operands; bubbles only move the valid bit.
            vld_d[0] = in_valid;
            if (in_valid) begin
                opa_d[0] = a;
                opb_d[0] = b ^ {WIDTH{sub}};
                cy_d[0]  = sub ? 1'b1 : c_in;
                res_d[0] = {WIDTH{1'b0}};
            end else begin
                opa_d[0] = opa_q[0];
            end

            // Intermediate stages: add slice k, forward operands.
            for (int k = 0; k < NSTG - 1; k++) begin
                vld_d[k+1] = vld_q[k];
                if (vld_q[k]) begin
                    add_v        = add_slice(opa_q[k], opb_q[k], res_q[k], cy_q[k], k);
                    res_d[k+1]   = add_v[WIDTH-1:0];
                    cy_d[k+1]    = add_v[WIDTH];
                    opa_d[k+1]   = opa_q[k];
                    opb_d[k+1]   = opb_q[k];
                end else begin
                    res_d[k+1]   = res_q[k+1];
                end
            end

            // Last stage: top slice, overflow and (optionally) saturation.
            // Invalid slots leave the output data registers untouched.
            vld_d[NSTG] = vld_q[NSTG-1];
            if (vld_q[NSTG-1]) begin
                add_v       = add_slice(opa_q[NSTG-1], opb_q[NSTG-1], res_q[NSTG-1],
                                        cy_q[NSTG-1], NSTG - 1);
                msb_a_v     = opa_q[NSTG-1][WIDTH-1];
                msb_b_v     = opb_q[NSTG-1][WIDTH-1];
                cy_d[NSTG]  = add_v[WIDTH];
                ovf_d       = (msb_a_v == msb_b_v) & (add_v[WIDTH-1] != msb_a_v);
                res_d[NSTG] = add_v[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
                if (ovf_d) begin
                    res_d[NSTG] = sat_value(msb_a_v);
                end else begin
                    res_d[NSTG] = add_v[WIDTH-1:0];
                end
`endif
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Pipeline registers; asynchronous reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= NSTG; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                res_q[k] <= {WIDTH{1'b0}};
            end
            for (int k = 0; k < NSTG; k++) begin
                opa_q[k] <= {WIDTH{1'b0}};
                opb_q[k] <= {WIDTH{1'b0}};
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k <= NSTG; k++) begin
                vld_q[k] <= vld_d[k];
                cy_q[k]  <= cy_d[k];
                res_q[k] <= res_d[k];
            end
            for (int k = 0; k < NSTG; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGE_W=4).
// A monitor predicts each accepted operation with plain integer arithmetic and
// compares results in acceptance order; directed cases check fixed values.

module tb_pipelined_addsub;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int NS = W / SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          c_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          ovf;

    pipelined_addsub #(.WIDTH(W), .STAGE_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic [31:0]  acc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    int           n_vec = 0;
    int           n_bad = 0;
    int           n_out = 0;
    int           cyc   = 0;
    logic         chk_lat = 1'b0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_c;
    logic         held_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap / range test.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic ts, input logic tc, input int acc);
        exp_t        r;
        logic [W-1:0] bn;
        int unsigned full;
        int          sa;
        int          sb;
        int          res;
        bn  = ~tb_;
        sa  = $signed(ta);
        sb  = $signed(tb_);
        if (ts) begin
            full = ta + bn + 32'd1;
            res  = sa - sb;
        end else begin
            full = ta + tb_ + {31'd0, tc};
            res  = sa + sb + int'(tc);
        end
        r.s   = full[W-1:0];
        r.c   = full[W];
        r.v   = (res > 32767) || (res < -32768);
        r.acc = acc;
`ifdef ADDSUB_SAT_EN
        if (r.v) r.s = ta[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return r[W-1:0];
        endcase
    endfunction

    // Monitor: handshake rules, held outputs, in-order results, latency.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_sum", sum, held_sum);
                    check("hold_cv", {c_out, ovf}, {held_c, held_v});
                end
                if (out_valid && !out_ready) begin
                    check("in_ready_stall", in_ready, 0);
                    stall_prev = 1'b1;
                    held_sum   = sum;
                    held_c     = c_out;
                    held_v     = ovf;
                end else begin
                    check("in_ready_free", in_ready, 1);
                    stall_prev = 1'b0;
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum", sum, e.s);
                        check("c_out", c_out, e.c);
                        check("ovf", ovf, e.v);
                        if (chk_lat) check("latency", 32'(cyc) - e.acc - 32'd1, NS);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, c_in, cyc));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc);
        in_valid = 1'b1;
        a = ta; b = tb_; sub = ts; c_in = tc;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                return;
            end
        end
        check("out_timeout", 0, 1);
    endtask

    task automatic one_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic ts, input logic tc,
                          input logic [W-1:0] xs, input logic xc, input logic xv);
        logic seen;
        apply(ta, tb_, ts, tc);
        in_valid = 1'b0;
        wait_out(seen);
        if (seen) begin
            check("dir_sum", sum, xs);
            check("dir_c_out", c_out, xc);
            check("dir_ovf", ovf, xv);
        end
        idle(2);
    endtask

    initial begin
        logic seen;
        logic acc;
        int   n0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cv", {c_out, ovf}, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        idle(2);

        // Directed arithmetic with exact latency.
        chk_lat = 1'b1;
        one_op(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0);
        one_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        one_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        one_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
        one_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
        one_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        one_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
        one_op(16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-to-back stream of 8 adds with a 3-cycle output stall.
        chk_lat = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) apply(pick(), pick(), 1'b0, 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            begin
                wait_out(seen);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(12);
        check("stream_drain", exp_q.size(), 0);
        check("stream_count", n_out - n0, 8);

        // Randomised mixed traffic with bubbles and back-pressure.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = pick(); b = pick();
                sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(15);
        check("random_drain", exp_q.size(), 0);

        // Reset with three operations in flight.
        chk_lat = 1'b1;
        apply(16'h1111, 16'h2222, 1'b0, 1'b0);
        apply(16'h3333, 16'h4444, 1'b1, 1'b0);
        apply(16'h5555, 16'h6666, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        stall_prev = 1'b0;
        exp_q.delete();
        #1 check("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(8);
        one_op(16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

        // Reset while a stalled result sits on the output.
        chk_lat = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) apply(16'h1000 + 16'(i), 16'h0F00, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_out(seen);
        #1 rst = 1'b1;
        stall_prev = 1'b0;
        exp_q.delete();
        #1;
        check("stallrst_out_valid", out_valid, 0);
        check("stallrst_sum", sum, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        idle(8);
        chk_lat = 1'b1;
        one_op(16'hAAAA, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        idle(4);
        check("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined N-bit adder/subtractor. It is the successor to the team's 4-bit ripple-carry adder.
- Operands are split into STAGE_W-bit slices. Each slice is added in its own pipeline stage, and the carry is registered between stages.
- This gives one result per clock at high frequency.
- Valid/ready handshakes on input and output let it sit between streaming datapath blocks.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of STAGE_W and at least 2.
- STAGE_W, 4, bits added per pipeline stage. Number of stages NSTG = WIDTH/STAGE_W, with 1 <= NSTG <= 16.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  a, b, sub and c_in are valid this cycle
- in_ready  out  1  block accepts the input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B+c_in; 1 = A-B (A + ~B + 1; c_in ignored)
- c_in  in  1  carry-in, add mode only
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result
- c_out  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (asynchronous, immediate):
  - All stage valid bits, out_valid, sum, c_out and ovf are forced to 0.
  - in_ready = 1 once rst is low.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready at a rising edge.
  - An output transfer occurs when out_valid & out_ready at a rising edge.
- Stall and ready:
  - stall = out_valid & ~out_ready. When stall is 1, every pipeline register holds and in_ready = 0.
  - in_ready = ~stall, evaluated combinationally. in_ready does not depend on in_valid.
- Stage k (0..NSTG-1):
  - Adds slice k of A and slice k of B' (B' = b XOR {WIDTH{sub}}) plus a carry.
  - Stage 0's carry is (sub ? 1 : c_in).
  - Stage k>0 takes the carry registered by stage k-1.
  - Upper slices not yet added are delayed in registers so the operands stay aligned with their carry.
  - Lower result slices already computed are carried forward in registers.
- Latency: exactly NSTG cycles from an accepted input to out_valid, with no stall. Throughput is 1 per cycle.
- Ordering: results leave in acceptance order. Bubbles (in_valid = 0) propagate as invalid slots and are not compressed.
- c_out is the carry from the last stage.
- ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]), computed in the last stage.
- Arithmetic:
  - Results wrap modulo 2^WIDTH.
  - Carry and overflow never alter sum, except under the optional feature.
- Held outputs: sum, c_out and ovf stay stable while out_valid & ~out_ready. They hold their last value when out_valid = 0.
- Simultaneous transfers: an output transfer and an input transfer in the same cycle are legal and lose nothing.
- Reset mid-operation: in-flight operations are discarded, no partial result is emitted, and the first input after reset release has full latency.
- Sub-mode operands: sub and c_in are captured with the operands. Mixed add/sub streams are processed per operation.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- When defined:
  - If ovf = 1, sum is replaced by the signed saturation value: 0111..1 when A[MSB] = 0, 1000..0 when A[MSB] = 1.
  - ovf is still reported.
  - c_out is unaffected.
- When undefined: sum is the wrapped result. No saturation logic is synthesised.

Test Plan (WIDTH=16, STAGE_W=4, NSTG=4):
- Reset, then a=0x1234, b=0x1111, sub=0, c_in=1, out_ready=1 → out_valid rises 4 cycles after acceptance.
  - sum=0x2346, c_out=0, ovf=0.
- a=0x0FFF, b=0x0001, add (full carry ripple across every stage boundary) → sum=0x1000, c_out=0, ovf=0.
  - a=0xFFFF, b=0x0001 → sum=0x0000, c_out=1.
- a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1 (0x8000 with ADDSUB_SAT_EN).
- Back-to-back stream of 8 adds:
  - Hold out_ready=0 for 3 cycles after the first output → in_ready=0 during the stall and sum held stable.
  - All 8 results arrive in order, with none dropped or duplicated.
- a=0x7FFF, b=0x0001, add → ovf=1. sum=0x8000 without the macro; sum=0x7FFF with ADDSUB_SAT_EN.
- Accept 3 inputs, assert rst for 1 cycle mid-pipeline → out_valid=0 immediately.
  - No stale result ever emerges.
  - The next input yields a correct result after 4 cycles.
